// File: rtl/seq_pkg.sv
// Shared types for the sequence generator/checker pair.
package seq_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } seq_chk_state_t;

  localparam int SEQ_W_DEFAULT = 32;

endpackage

// File: rtl/seq_hist.sv
// Three-deep history of the sequence; exp is the next value the recurrence predicts.
module seq_hist #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         shift_en,
  input  logic [W-1:0] shift_data,
  output logic [W-1:0] h0,
  output logic [W-1:0] h1,
  output logic [W-1:0] h2,
  output logic [W-1:0] exp
);

  logic [W-1:0] h0_r;
  logic [W-1:0] h1_r;
  logic [W-1:0] h2_r;

  // shift register, h0 oldest
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h0_r <= {W{1'b0}};
      h1_r <= {W{1'b0}};
      h2_r <= {W{1'b0}};
    end else if (clr) begin
      h0_r <= {W{1'b0}};
      h1_r <= {W{1'b0}};
      h2_r <= {W{1'b0}};
    end else if (shift_en) begin
      h0_r <= h1_r;
      h1_r <= h2_r;
      h2_r <= shift_data;
    end
  end

  assign h0  = h0_r;
  assign h1  = h1_r;
  assign h2  = h2_r;
  assign exp = h0_r + h1_r;

endmodule

// File: rtl/seq_checker.sv
// Recurrence checker: locks onto s(n+3)=s(n)+s(n+1) and counts broken beats.
// Optional first-error capture ports when SEQ_CHECKER_CAPTURE_EN is defined.
module seq_checker
  import seq_pkg::*;
#(
  parameter int W      = SEQ_W_DEFAULT,
  parameter int LOCK_N = 4,
  parameter int LOSS_N = 3,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
`ifdef SEQ_CHECKER_CAPTURE_EN
  output logic [W-1:0]  first_got,
  output logic [W-1:0]  first_exp,
  output logic          first_vld,
`endif
  output logic          locked,
  output logic          err_pulse,
  output logic [CW-1:0] err_count,
  output logic [1:0]    state_o
);

  localparam int MC_W = $clog2(LOCK_N + 1);
  localparam int MS_W = $clog2(LOSS_N + 1);

  seq_chk_state_t state_r;
  logic [1:0]     fill_r;
  logic [MC_W-1:0] match_cnt_r;
  logic [MS_W-1:0] miss_cnt_r;
  logic           locked_r;
  logic           err_pulse_r;
  logic [CW-1:0]  err_count_r;

  logic [W-1:0]   exp_s;
  logic [W-1:0]   h0_s;
  logic [W-1:0]   h1_s;
  logic [W-1:0]   h2_s;
  logic [W-1:0]   shift_data_s;
  logic           beat_s;
  logic           match_s;
  logic           hist_unused_s;

  seq_hist #(.W(W)) u_hist (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .shift_en   (beat_s),
    .shift_data (shift_data_s),
    .h0         (h0_s),
    .h1         (h1_s),
    .h2         (h2_s),
    .exp        (exp_s)
  );

  assign hist_unused_s = ^{h0_s, h1_s, h2_s};

  // a mismatch while locked flywheels the prediction instead of the corrupt beat
  always_comb begin
    beat_s       = in_valid && !clr;
    match_s      = (in_data == exp_s);
    shift_data_s = in_data;
    if ((state_r == LOCKED) && !match_s) begin
      shift_data_s = exp_s;
    end else begin
      shift_data_s = in_data;
    end
  end

  // lock FSM, counters and registered status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= HUNT;
      fill_r      <= 2'd0;
      match_cnt_r <= {MC_W{1'b0}};
      miss_cnt_r  <= {MS_W{1'b0}};
      locked_r    <= 1'b0;
      err_pulse_r <= 1'b0;
      err_count_r <= {CW{1'b0}};
    end else if (clr) begin
      state_r     <= HUNT;
      fill_r      <= 2'd0;
      match_cnt_r <= {MC_W{1'b0}};
      miss_cnt_r  <= {MS_W{1'b0}};
      locked_r    <= 1'b0;
      err_pulse_r <= 1'b0;
      err_count_r <= {CW{1'b0}};
    end else begin
      err_pulse_r <= 1'b0;
      if (in_valid) begin
        case (state_r)
          HUNT: begin
            if (fill_r == 2'd2) begin
              fill_r  <= 2'd3;
              state_r <= TRACK;
            end else begin
              fill_r <= fill_r + 2'd1;
            end
          end
          TRACK: begin
            if (!match_s) begin
              match_cnt_r <= {MC_W{1'b0}};
            end else if (match_cnt_r == MC_W'(LOCK_N - 1)) begin
              match_cnt_r <= {MC_W{1'b0}};
              state_r     <= LOCKED;
              locked_r    <= 1'b1;
            end else begin
              match_cnt_r <= match_cnt_r + MC_W'(1);
            end
          end
          LOCKED: begin
            if (match_s) begin
              miss_cnt_r <= {MS_W{1'b0}};
            end else begin
              err_pulse_r <= 1'b1;
              if (err_count_r != {CW{1'b1}}) begin
                err_count_r <= err_count_r + CW'(1);
              end
              if (miss_cnt_r == MS_W'(LOSS_N - 1)) begin
                state_r     <= HUNT;
                locked_r    <= 1'b0;
                fill_r      <= 2'd0;
                miss_cnt_r  <= {MS_W{1'b0}};
                match_cnt_r <= {MC_W{1'b0}};
              end else begin
                miss_cnt_r <= miss_cnt_r + MS_W'(1);
              end
            end
          end
          default: begin
            state_r  <= HUNT;
            locked_r <= 1'b0;
            fill_r   <= 2'd0;
          end
        endcase
      end
    end
  end

`ifdef SEQ_CHECKER_CAPTURE_EN
  logic [W-1:0] first_got_r;
  logic [W-1:0] first_exp_r;
  logic         first_vld_r;

  // latch only the first locked mismatch since reset/clr
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_got_r <= {W{1'b0}};
      first_exp_r <= {W{1'b0}};
      first_vld_r <= 1'b0;
    end else if (clr) begin
      first_got_r <= {W{1'b0}};
      first_exp_r <= {W{1'b0}};
      first_vld_r <= 1'b0;
    end else if (in_valid && (state_r == LOCKED) && !match_s && !first_vld_r) begin
      first_got_r <= in_data;
      first_exp_r <= exp_s;
      first_vld_r <= 1'b1;
    end
  end

  assign first_got = first_got_r;
  assign first_exp = first_exp_r;
  assign first_vld = first_vld_r;
`endif

  assign locked    = locked_r;
  assign err_pulse = err_pulse_r;
  assign err_count = err_count_r;
  assign state_o   = state_r;

endmodule

// File: tb/tb_seq_checker.sv
// Table-driven bench for seq_checker with a queue scoreboard.
module tb_seq_checker;

  typedef struct {
    logic        v;
    logic        c;
    logic [31:0] d;
    logic        lk;
    logic        ep;
    logic [15:0] ec;
    logic [1:0]  st;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [1:0]  state_o;
`ifdef SEQ_CHECKER_CAPTURE_EN
  logic [31:0] first_got;
  logic [31:0] first_exp;
  logic        first_vld;
`endif

  int total = 0;
  int bad = 0;
  vec_t vecs[$];
  vec_t sb[$];

  localparam logic [31:0] A = 32'h8000_0000;

  seq_checker dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef SEQ_CHECKER_CAPTURE_EN
    .first_got (first_got),
    .first_exp (first_exp),
    .first_vld (first_vld),
`endif
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", nm, got, want);
    end
  endtask

  task automatic add(input logic v, input logic c, input logic [31:0] d, input logic lk,
                     input logic ep, input logic [15:0] ec, input logic [1:0] st);
    vec_t e;
    e.v = v; e.c = c; e.d = d; e.lk = lk; e.ep = ep; e.ec = ec; e.st = st;
    vecs.push_back(e);
  endtask

  task automatic run_table(input string tag);
    vec_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      in_valid = vecs[i].v;
      clr      = vecs[i].c;
      in_data  = vecs[i].d;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("%s%0d_locked", tag, i), {31'd0, locked}, {31'd0, e.lk});
      chk($sformatf("%s%0d_err_pulse", tag, i), {31'd0, err_pulse}, {31'd0, e.ep});
      chk($sformatf("%s%0d_err_count", tag, i), {16'd0, err_count}, {16'd0, e.ec});
      chk($sformatf("%s%0d_state", tag, i), {30'd0, state_o}, {30'd0, e.st});
    end
    @(negedge clk);
    in_valid = 1'b0;
    clr      = 1'b0;
    vecs.delete();
  endtask

  // 0,1,1,1,2,2,3 from a cleared state: locks on the 7th beat
  task automatic add_lock_seq(input logic [15:0] ec);
    add(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, ec, 2'd0);
    add(1'b1, 1'b0, 32'd1, 1'b0, 1'b0, ec, 2'd0);
    add(1'b1, 1'b0, 32'd1, 1'b0, 1'b0, ec, 2'd1);
    add(1'b1, 1'b0, 32'd1, 1'b0, 1'b0, ec, 2'd1);
    add(1'b1, 1'b0, 32'd2, 1'b0, 1'b0, ec, 2'd1);
    add(1'b1, 1'b0, 32'd2, 1'b0, 1'b0, ec, 2'd1);
    add(1'b1, 1'b0, 32'd3, 1'b1, 1'b0, ec, 2'd2);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset state, lock, single error with flywheel, loss of lock, wrap, clr+beat
    add(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0, 2'd0);
    add_lock_seq(16'd0);
    add(1'b1, 1'b0, 32'd4,  1'b1, 1'b0, 16'd0, 2'd2);
    add(1'b1, 1'b0, 32'd5,  1'b1, 1'b0, 16'd0, 2'd2);
    add(1'b1, 1'b0, 32'd9,  1'b1, 1'b1, 16'd1, 2'd2);
    add(1'b1, 1'b0, 32'd9,  1'b1, 1'b0, 16'd1, 2'd2);
    add(1'b1, 1'b0, 32'd12, 1'b1, 1'b0, 16'd1, 2'd2);
    add(1'b1, 1'b0, 32'd16, 1'b1, 1'b0, 16'd1, 2'd2);
    add(1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 16'd1, 2'd2);
    add(1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 16'd2, 2'd2);
    add(1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 16'd3, 2'd2);
    add(1'b1, 1'b0, 32'd0,  1'b0, 1'b1, 16'd4, 2'd0);
    add(1'b1, 1'b0, A,      1'b0, 1'b0, 16'd4, 2'd0);
    add(1'b1, 1'b0, A,      1'b0, 1'b0, 16'd4, 2'd0);
    add(1'b1, 1'b0, A,      1'b0, 1'b0, 16'd4, 2'd1);
    add(1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 16'd4, 2'd1);
    add(1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 16'd4, 2'd1);
    add(1'b1, 1'b0, A,      1'b0, 1'b0, 16'd4, 2'd1);
    add(1'b1, 1'b0, 32'd0,  1'b1, 1'b0, 16'd4, 2'd2);
    add(1'b1, 1'b0, A,      1'b1, 1'b0, 16'd4, 2'd2);
    add(1'b1, 1'b0, A,      1'b1, 1'b0, 16'd4, 2'd2);
    add(1'b1, 1'b0, A,      1'b1, 1'b0, 16'd4, 2'd2);
    add(1'b1, 1'b0, 32'd0,  1'b1, 1'b0, 16'd4, 2'd2);
    add(1'b1, 1'b0, 32'd5,  1'b1, 1'b1, 16'd5, 2'd2);
    add(1'b1, 1'b1, A,      1'b0, 1'b0, 16'd0, 2'd0);
    add(1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 16'd0, 2'd0);
    add_lock_seq(16'd0);
    add(1'b1, 1'b0, 32'd100, 1'b1, 1'b1, 16'd1, 2'd2);
    run_table("a");

    // asynchronous reset between clock edges takes effect immediately
    #2;
    reset = 1'b1;
    #1;
    chk("async_locked", {31'd0, locked}, 32'd0);
    chk("async_err_pulse", {31'd0, err_pulse}, 32'd0);
    chk("async_err_count", {16'd0, err_count}, 32'd0);
    chk("async_state", {30'd0, state_o}, 32'd0);
`ifdef SEQ_CHECKER_CAPTURE_EN
    chk("async_first_vld", {31'd0, first_vld}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // relock takes 3+LOCK_N beats, then errors 9-for-7 and 20-for-16
    add_lock_seq(16'd0);
    add(1'b1, 1'b0, 32'd4,  1'b1, 1'b0, 16'd0, 2'd2);
    add(1'b1, 1'b0, 32'd5,  1'b1, 1'b0, 16'd0, 2'd2);
    add(1'b1, 1'b0, 32'd9,  1'b1, 1'b1, 16'd1, 2'd2);
    add(1'b1, 1'b0, 32'd9,  1'b1, 1'b0, 16'd1, 2'd2);
    add(1'b1, 1'b0, 32'd12, 1'b1, 1'b0, 16'd1, 2'd2);
    add(1'b1, 1'b0, 32'd20, 1'b1, 1'b1, 16'd2, 2'd2);
    add(1'b1, 1'b0, 32'd21, 1'b1, 1'b0, 16'd2, 2'd2);
    run_table("c");
`ifdef SEQ_CHECKER_CAPTURE_EN
    chk("first_got", first_got, 32'd9);
    chk("first_exp", first_exp, 32'd7);
    chk("first_vld", {31'd0, first_vld}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
